// File: rtl/dds_sweep_nco.sv
`default_nettype none
// ============================================================================
// Module  : dds_sweep_nco
// Purpose : Multi-channel DDFS phase generator with programmable FCW sweep
//           (tone, one-shot up-chirp, sawtooth, triangle).
// Revision: 1.0 - initial release
// ============================================================================
module dds_sweep_nco #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 20,
    parameter int NCH     = 2,
    parameter int DWELL_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [1:0]               cfg_mode,
    input  logic [ACC_W-1:0]         cfg_fcw_start,
    input  logic [ACC_W-1:0]         cfg_fcw_stop,
    input  logic [ACC_W-1:0]         cfg_step,
    input  logic [DWELL_W-1:0]       cfg_dwell,
    input  logic [NCH*ACC_W-1:0]     cfg_poff,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic [ACC_W-1:0]         fcw_out,
    output logic [NCH*PHASE_W-1:0]   phase_out,
    output logic                     phase_valid,
    output logic                     sweep_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] C_MODE_TONE = 2'b00;
    localparam logic [1:0] C_MODE_ONCE = 2'b01;
    localparam logic [1:0] C_MODE_SAW  = 2'b10;
    localparam logic [1:0] C_MODE_TRI  = 2'b11;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [1:0]               r_mode;
    logic [ACC_W-1:0]         r_start;
    logic [ACC_W-1:0]         r_stop;
    logic [ACC_W-1:0]         r_step;
    logic [DWELL_W-1:0]       r_dwell;
    logic [NCH*ACC_W-1:0]     r_poff;

    logic [ACC_W-1:0]         r_acc;
    logic [ACC_W-1:0]         r_fcw;
    logic [ACC_W-1:0]         w_fcw_nxt;
    logic [DWELL_W-1:0]       r_dwell_cnt;
    logic [DWELL_W-1:0]       w_dwell_cnt_nxt;
    logic                     r_done;
    logic                     w_done_nxt;
    logic                     r_valid;
    logic [NCH*PHASE_W-1:0]   r_phase;
    logic [NCH*PHASE_W-1:0]   w_phase;

    logic                     w_cfg_take;
    logic                     w_launch;
    logic                     w_degen;
    logic                     w_expire;
    logic                     w_run;
    logic [ACC_W:0]           w_up_sum;
    logic [ACC_W:0]           w_dn_diff;

    assign cfg_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign fcw_out     = r_fcw;
    assign phase_out   = r_phase;
    assign phase_valid = r_valid;
    assign sweep_done  = r_done;

    assign w_cfg_take = cfg_valid & cfg_ready;
    assign w_launch   = (r_state == IDLE) & start & ~abort;
    assign w_run      = (r_state != IDLE) & ~abort;
    assign w_degen    = (r_step == '0) | (r_stop < r_start);
    assign w_expire   = (r_dwell_cnt == r_dwell);
    // One extra bit catches carry past 2^ACC_W and borrow below zero.
    assign w_up_sum   = {1'b0, r_fcw} + {1'b0, r_step};
    assign w_dn_diff  = {1'b0, r_fcw} - {1'b0, r_step};

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            logic [ACC_W-1:0] w_off_sum;
            assign w_off_sum = r_acc + r_poff[k*ACC_W +: ACC_W];
            assign w_phase[k*PHASE_W +: PHASE_W] = w_off_sum[ACC_W-1 -: PHASE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_fcw_nxt       = r_fcw;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_done_nxt      = 1'b0;
        if (r_state == IDLE) begin
            if (w_launch) begin
                w_fcw_nxt       = r_start;
                w_dwell_cnt_nxt = '0;
                w_state_nxt     = ((r_mode == C_MODE_TONE) || w_degen) ? HOLD : UP;
            end
        end else if (abort) begin
            w_state_nxt = IDLE;
        end else if (!w_expire) begin
            w_dwell_cnt_nxt = r_dwell_cnt + 1'b1;
        end else begin
            w_dwell_cnt_nxt = '0;
            case (r_state)
                UP: begin
                    // Sawtooth sits at stop for one dwell period, then restarts.
                    if ((r_mode == C_MODE_SAW) && (r_fcw == r_stop)) begin
                        w_fcw_nxt = r_start;
                    end else if (w_up_sum >= {1'b0, r_stop}) begin
                        w_fcw_nxt  = r_stop;
                        w_done_nxt = 1'b1;
                        if (r_mode == C_MODE_ONCE) begin
                            w_state_nxt = HOLD;
                        end else if (r_mode == C_MODE_TRI) begin
                            w_state_nxt = DOWN;
                        end
                    end else begin
                        w_fcw_nxt = w_up_sum[ACC_W-1:0];
                    end
                end
                DOWN: begin
                    if (w_dn_diff[ACC_W] || (w_dn_diff[ACC_W-1:0] <= r_start)) begin
                        w_fcw_nxt   = r_start;
                        w_state_nxt = UP;
                    end else begin
                        w_fcw_nxt = w_dn_diff[ACC_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= '0;
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_poff  <= '0;
        end else if (w_cfg_take) begin
            r_mode  <= cfg_mode;
            r_start <= cfg_fcw_start;
            r_stop  <= cfg_fcw_stop;
            r_step  <= cfg_step;
            r_dwell <= cfg_dwell;
            r_poff  <= cfg_poff;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_fcw       <= '0;
            r_dwell_cnt <= '0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_phase     <= '0;
        end else begin
            r_fcw       <= w_fcw_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_done      <= w_done_nxt;
            if (w_launch) begin
                r_acc   <= '0;
                r_valid <= 1'b0;
            end else if (w_run) begin
                // Phase is taken from the accumulator before this cycle's add.
                r_acc   <= r_acc + r_fcw;
                r_phase <= w_phase;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_nco.sv
`default_nettype none
// ============================================================================
// Module  : tb_dds_sweep_nco
// Purpose : Randomised self-checking bench for dds_sweep_nco against a
//           trajectory-list reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dds_sweep_nco;

    localparam int ACC_W   = 32;
    localparam int PHASE_W = 20;
    localparam int NCH     = 2;
    localparam int DWELL_W = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [1:0]             cfg_mode = '0;
    logic [ACC_W-1:0]       cfg_fcw_start = '0;
    logic [ACC_W-1:0]       cfg_fcw_stop = '0;
    logic [ACC_W-1:0]       cfg_step = '0;
    logic [DWELL_W-1:0]     cfg_dwell = '0;
    logic [NCH*ACC_W-1:0]   cfg_poff = '0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   busy;
    logic [ACC_W-1:0]       fcw_out;
    logic [NCH*PHASE_W-1:0] phase_out;
    logic                   phase_valid;
    logic                   sweep_done;

    always #5 clk = ~clk;

    dds_sweep_nco #(
        .ACC_W   (ACC_W),
        .PHASE_W (PHASE_W),
        .NCH     (NCH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mode      (cfg_mode),
        .cfg_fcw_start (cfg_fcw_start),
        .cfg_fcw_stop  (cfg_fcw_stop),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_poff      (cfg_poff),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .fcw_out       (fcw_out),
        .phase_out     (phase_out),
        .phase_valid   (phase_valid),
        .sweep_done    (sweep_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model configuration and expected FCW level list (one entry per dwell period).
    logic [1:0]          m_mode;
    logic [ACC_W-1:0]    m_start;
    logic [ACC_W-1:0]    m_stop;
    logic [ACC_W-1:0]    m_step;
    int                  m_dwell;
    logic [ACC_W-1:0]    m_poff [NCH];
    longint unsigned     lv[$];
    bit                  dn[$];

    task automatic build_model(input int len);
        longint unsigned up[$];
        longint unsigned cyc[$];
        longint unsigned v;
        longint          d;
        bit              degen;
        bit              reached;
        int              idx;
        lv.delete();
        dn.delete();
        degen = (m_step == 0) || (m_stop < m_start);
        if (m_mode == 2'b00 || degen) begin
            for (int i = 0; i < len; i++) begin
                lv.push_back(longint'(m_start));
                dn.push_back(1'b0);
            end
        end else begin
            v = longint'(m_start);
            up.push_back(v);
            while (v < longint'(m_stop) && up.size() < len) begin
                v = v + longint'(m_step);
                if (v > longint'(m_stop)) v = longint'(m_stop);
                up.push_back(v);
            end
            reached = (up[up.size()-1] == longint'(m_stop));
            cyc = up;
            if (m_mode == 2'b11 && reached) begin
                for (longint k = 1; cyc.size() < 2*len; k++) begin
                    d = longint'(m_stop) - k * longint'(m_step);
                    if (d <= longint'(m_start)) break;
                    cyc.push_back(longint'(d));
                end
            end
            for (int i = 0; i < len; i++) begin
                if (m_mode == 2'b01) begin
                    idx = (i < up.size()) ? i : up.size() - 1;
                    lv.push_back(up[idx]);
                    dn.push_back(i > 0 && reached && i == up.size() - 1);
                end else begin
                    idx = i % cyc.size();
                    lv.push_back(cyc[idx]);
                    dn.push_back(i > 0 && reached && idx == up.size() - 1);
                end
            end
        end
    endtask

    function automatic logic [NCH*PHASE_W-1:0] exp_phase(input logic [ACC_W-1:0] acc);
        logic [NCH*PHASE_W-1:0] r;
        logic [ACC_W-1:0]       s;
        for (int k = 0; k < NCH; k++) begin
            s = acc + m_poff[k];
            r[k*PHASE_W +: PHASE_W] = s[ACC_W-1 -: PHASE_W];
        end
        return r;
    endfunction

    task automatic set_cfg(input logic [1:0] mode, input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] st, input int dw, input logic [31:0] p0, input logic [31:0] p1);
        m_mode = mode; m_start = s; m_stop = e; m_step = st; m_dwell = dw;
        m_poff[0] = p0; m_poff[1] = p1;
    endtask

    // Launch the model's config, follow ncyc cycles, optionally abort at the end.
    task automatic run_sweep(input string name, input int ncyc, input bit load,
                             input bit poke, input bit do_abort);
        logic [ACC_W-1:0]       macc;
        logic [NCH*PHASE_W-1:0] ph;
        int                     per;
        per = m_dwell + 1;
        build_model(ncyc + 1);
        @(posedge clk); #1;
        if (load) begin
            cfg_valid = 1'b1; cfg_mode = m_mode; cfg_fcw_start = m_start; cfg_fcw_stop = m_stop;
            cfg_step = m_step; cfg_dwell = DWELL_W'(m_dwell); cfg_poff = {m_poff[1], m_poff[0]};
            @(posedge clk); #1;
            cfg_valid = 1'b0;
        end
        check({name, " ready_idle"}, 64'(cfg_ready), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy_e0"}, 64'(busy), 64'd1);
        check({name, " valid_e0"}, 64'(phase_valid), 64'd0);
        check({name, " fcw_e0"}, 64'(fcw_out), lv[0]);
        macc = '0;
        ph = '0;
        for (int n = 1; n <= ncyc; n++) begin
            if (poke && n == 3) begin
                cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_fcw_start = 32'hDEAD0000;
                cfg_fcw_stop = 32'hDEADFFFF; cfg_step = 32'h1; cfg_dwell = '0; cfg_poff = '1;
                start = 1'b1;
                check({name, " ready_busy"}, 64'(cfg_ready), 64'd0);
            end
            @(posedge clk); #1;
            cfg_valid = 1'b0;
            start = 1'b0;
            ph = exp_phase(macc);
            check({name, " fcw"}, 64'(fcw_out), lv[n / per]);
            check({name, " done"}, 64'(sweep_done), 64'(dn[n / per] && (n % per == 0)));
            check({name, " valid"}, 64'(phase_valid), 64'd1);
            check({name, " phase"}, 64'(phase_out), 64'(ph));
            macc = macc + ACC_W'(lv[(n - 1) / per]);
        end
        if (do_abort) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check({name, " abort_busy"}, 64'(busy), 64'd0);
            check({name, " abort_valid"}, 64'(phase_valid), 64'd0);
            check({name, " abort_fcw"}, 64'(fcw_out), lv[ncyc / per]);
            check({name, " abort_phase"}, 64'(phase_out), 64'(ph));
            check({name, " abort_done"}, 64'(sweep_done), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] s, e, st;
        logic [1:0]  md;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fcw", 64'(fcw_out), 64'd0);
        check("rst_phase", 64'(phase_out), 64'd0);
        check("rst_valid", 64'(phase_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(cfg_ready), 64'd1);
        check("rst_done", 64'(sweep_done), 64'd0);
        rst = 1'b1;

        set_cfg(2'b00, 32'h12345678, 32'h0, 32'h0, 0, 32'h0, 32'h40000000);
        run_sweep("tone", 6, 1'b1, 1'b1, 1'b1);
        set_cfg(2'b01, 32'h100, 32'h400, 32'h100, 1, 32'h0, 32'h12345678);
        run_sweep("once", 12, 1'b1, 1'b0, 1'b1);
        set_cfg(2'b01, 32'hFFFFFF00, 32'hFFFFFFF0, 32'h80, 0, 32'h0, 32'h0);
        run_sweep("ovf", 6, 1'b1, 1'b0, 1'b1);
        set_cfg(2'b11, 32'h10, 32'h30, 32'h10, 0, 32'h0, 32'h80000000);
        run_sweep("tri", 10, 1'b1, 1'b1, 1'b1);
        run_sweep("tri_again", 8, 1'b0, 1'b0, 1'b1);
        set_cfg(2'b10, 32'h1000, 32'h4000, 32'h1000, 2, 32'h0, 32'h0);
        run_sweep("saw", 20, 1'b1, 1'b0, 1'b1);
        set_cfg(2'b00, 32'h80000000, 32'h0, 32'h0, 0, 32'h0, 32'h0);
        run_sweep("wrap", 4, 1'b1, 1'b0, 1'b1);

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_valid", 64'(phase_valid), 64'd0);

        for (int r = 0; r < 24; r++) begin
            md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                s = 32'hFFFF0000 + $urandom_range(0, 32'hFF);
                e = 32'hFFFFFFFF - $urandom_range(0, 32'hFF);
                st = $urandom_range(32'h1000, 32'h9000);
            end else begin
                s = $urandom_range(0, 32'hFFFE0000);
                e = s + $urandom_range(1, 32'h10000);
                st = $urandom_range(1, 32'h6000);
            end
            if ($urandom_range(0, 9) == 0) st = 32'h0;
            if ($urandom_range(0, 9) == 0) e = s - 32'd1 - $urandom_range(0, 32'hFF);
            set_cfg(md, s, e, st, $urandom_range(0, 3), $urandom, $urandom);
            run_sweep("rand", 30, 1'b1, r[0], 1'b1);
        end

        set_cfg(2'b11, 32'h100, 32'h900, 32'h100, 0, 32'h5, 32'h6);
        run_sweep("pre_rst", 5, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_fcw", 64'(fcw_out), 64'd0);
        check("arst_phase", 64'(phase_out), 64'd0);
        check("arst_valid", 64'(phase_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(sweep_done), 64'd0);
        check("arst_ready", 64'(cfg_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
